seq_comp: RTL

Parametrised multi-cycle magnitude comparator, the successor to the 4-bit single-cycle comparator. Compares two WIDTH-bit operands CHUNK bits per cycle, most significant chunk first. Supports a runtime signed/unsigned mode and optional early exit. Uses a start/busy/done handshake, and registered gt/eq/lt results are held until the next result. Sits beside the ALU as a shared compare resource for wide operands.

---
 rtl/comp_pkg.sv | 26 ++
 rtl/comp_chunk.sv | 28 ++
 rtl/seq_comp.sv | 123 ++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared definitions for the multi-cycle magnitude comparator.
//   state_e      : FSM state encoding (IDLE/RUN/FIN)
//   RES_*        : {gt,eq,lt} result encodings
//   nchunk()     : number of CHUNK-bit slices in a WIDTH-bit operand
//   idx_w()      : chunk-index register width (clog2 of NCHUNK, at least 1)
package comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_e;

    localparam logic [2:0] RES_GT = 3'b100;
    localparam logic [2:0] RES_EQ = 3'b010;
    localparam logic [2:0] RES_LT = 3'b001;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational compare of one CHUNK-bit slice.
//   ca_i, cb_i  : slices of operand A and B
//   msb_flip_i  : invert the slice MSB of both sides (signed top chunk)
//   chunk_gt_o  : ca > cb after the optional flip
//   chunk_lt_o  : ca < cb after the optional flip
module comp_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] ca_i,
    input  logic [CHUNK-1:0] cb_i,
    input  logic             msb_flip_i,
    output logic             chunk_gt_o,
    output logic             chunk_lt_o
);

    localparam logic [CHUNK-1:0] MSB = CHUNK'(1) << (CHUNK - 1);

    logic [CHUNK-1:0] xa, xb;

    // Flipping the sign bit maps two's complement onto offset binary,
    // so a plain unsigned compare gives the signed ordering.
    assign xa = ca_i ^ (msb_flip_i ? MSB : '0);
    assign xb = cb_i ^ (msb_flip_i ? MSB : '0);

    assign chunk_gt_o = (xa > xb);
    assign chunk_lt_o = (xa < xb);

endmodule

// File: rtl/seq_comp.sv
// Multi-cycle WIDTH-bit magnitude comparator, CHUNK bits per cycle, MSB first.
//   clk, reset : clock, synchronous active-high reset
//   start      : request, accepted in IDLE or FIN (back-to-back)
//   is_signed  : two's-complement compare when 1; sampled on accept
//   a, b       : operands; sampled on accept
//   busy       : compare cycles in progress
//   done       : one-cycle pulse when gt/eq/lt are updated
//   gt, eq, lt : registered result, held until the next done
module seq_comp
    import comp_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 4,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int IW     = idx_w(NCHUNK);
    localparam logic [IW-1:0] TOP_IDX = IW'(NCHUNK - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             sgn_q;
    logic [IW-1:0]    idx_q;
    logic             dec_q;     // a higher chunk already decided the result
    logic             pgt_q;     // decided direction: 1 = gt, 0 = lt
    logic             busy_q, done_q;
    logic [2:0]       res_q;

    logic [CHUNK-1:0] ca, cb;
    logic             cgt, clt;
    logic [2:0]       res_d;
    logic             fin_d;

    assign ca = a_q[idx_q*CHUNK +: CHUNK];
    assign cb = b_q[idx_q*CHUNK +: CHUNK];

    comp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .ca_i       (ca),
        .cb_i       (cb),
        .msb_flip_i (sgn_q && (idx_q == TOP_IDX)),
        .chunk_gt_o (cgt),
        .chunk_lt_o (clt)
    );

    // Result if the compare finishes this cycle: an earlier decision wins
    // over whatever the current (less significant) chunk says.
    always_comb begin
        res_d = RES_EQ;
        if (dec_q)    res_d = pgt_q ? RES_GT : RES_LT;
        else if (cgt) res_d = RES_GT;
        else if (clt) res_d = RES_LT;
    end

    assign fin_d = (idx_q == '0) || (EARLY_EXIT && (cgt || clt));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            dec_q   <= 1'b0;
            pgt_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            case (state_q)
                IDLE, FIN: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        sgn_q   <= is_signed;
                        idx_q   <= TOP_IDX;
                        dec_q   <= 1'b0;
                        pgt_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    if (fin_d) begin
                        res_q   <= res_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FIN;
                    end else begin
                        idx_q <= idx_q - 1'b1;
                        if (!dec_q && (cgt || clt)) begin
                            dec_q <= 1'b1;
                            pgt_q <= cgt;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign gt   = res_q[2];
    assign eq   = res_q[1];
    assign lt   = res_q[0];

endmodule
